// File: rtl/param_cpu_core_pkg.sv
// Shared opcodes, FSM states and PSW bit positions for param_cpu_core.
package cpu_core_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd1;
  localparam logic [OP_W-1:0] OP_STORE = 4'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OP_W-1:0] OP_AND   = 4'd5;
  localparam logic [OP_W-1:0] OP_OR    = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd8;
  localparam logic [OP_W-1:0] OP_LDI   = 4'd9;
  localparam logic [OP_W-1:0] OP_OUT   = 4'd10;
  localparam logic [OP_W-1:0] OP_EI    = 4'd11;
  localparam logic [OP_W-1:0] OP_DI    = 4'd12;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_IRQ  = 2'd3;

  localparam int PSW_Z = 0;
  localparam int PSW_C = 1;
  localparam int PSW_N = 2;
  localparam int PSW_V = 3;

endpackage

// File: rtl/param_cpu_core_if.sv
// Instruction valid/ready handshake between a source and the core.
interface param_cpu_core_if #(
  parameter int INSTR_W = 18
);
  logic [INSTR_W-1:0] instr_i;
  logic               instr_valid_i;
  logic               instr_ready_o;

  modport master (
    output instr_i,
    output instr_valid_i,
    input  instr_ready_o
  );

  modport slave (
    input  instr_i,
    input  instr_valid_i,
    output instr_ready_o
  );
endinterface

// File: rtl/param_cpu_core_alu.sv
// Combinational ALU for param_cpu_core; flags returned as {V,N,C,Z}.
// Define CPU_SAT_ARITH_EN for saturating ADD/SUB.
module cpu_alu
  import cpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_op,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_dif;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (1'b1)
      (i_op == OP_ADD): begin
        w_c   = w_sum[DATA_W];
        w_res = w_sum[DATA_W-1:0];
`ifdef CPU_SAT_ARITH_EN
        if (w_c) w_res = '1;
`endif
        w_v = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
              (w_res[DATA_W-1] != i_a[DATA_W-1]);
      end
      (i_op == OP_SUB): begin
        w_c   = w_dif[DATA_W];
        w_res = w_dif[DATA_W-1:0];
`ifdef CPU_SAT_ARITH_EN
        if (w_c) w_res = '0;
`endif
        w_v = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
              (w_res[DATA_W-1] != i_a[DATA_W-1]);
      end
      (i_op == OP_AND): w_res = i_a & i_b;
      (i_op == OP_OR):  w_res = i_a | i_b;
      (i_op == OP_XOR): w_res = i_a ^ i_b;
      (i_op == OP_NOT): w_res = ~i_b;
      default: ;
    endcase
  end

  always_comb begin
    o_flags        = '0;
    o_flags[PSW_Z] = (w_res == '0);
    o_flags[PSW_C] = w_c;
    o_flags[PSW_N] = w_res[DATA_W-1];
    o_flags[PSW_V] = w_v;
  end

  assign o_result = w_res;

endmodule

// File: rtl/param_cpu_core.sv
// Parametrised multi-cycle core: regfile, ALU, PSW, data memory, one-level IRQ.
// Define CPU_SAT_ARITH_EN for saturating ADD/SUB in the ALU.
module param_cpu_core
  import cpu_core_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          NREGS     = 8,
  parameter int          MEM_DEPTH = 256,
  parameter int unsigned IRQ_VEC   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  param_cpu_core_if.slave   ifc,
  input  logic              irq_i,
  output logic              irq_ack_o,
  output logic [$clog2(MEM_DEPTH)-1:0] irq_vec_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic [3:0]        psw_o,
  output logic              ie_o,
  output logic              illegal_o
);

  localparam int RA_W    = $clog2(NREGS);
  localparam int ADDR_W  = $clog2(MEM_DEPTH);
  localparam int INSTR_W = OP_W + 2 * RA_W + ADDR_W;

  logic [1:0]         r_state;
  logic [INSTR_W-1:0] r_ir;
  logic [DATA_W-1:0]  r_regs [NREGS];
  logic [DATA_W-1:0]  r_mem [MEM_DEPTH];
  logic [DATA_W-1:0]  r_rdata;
  logic [DATA_W-1:0]  r_dout;
  logic [3:0]         r_psw;
  logic               r_ie;
  logic               r_dout_v;
  logic               r_ill;

  logic [OP_W-1:0]   w_op;
  logic [RA_W-1:0]   w_rd;
  logic [RA_W-1:0]   w_rs;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_res;
  logic [3:0]        w_alu_flags;

  assign w_op   = r_ir[INSTR_W-1 -: OP_W];
  assign w_rd   = r_ir[INSTR_W-OP_W-1 -: RA_W];
  assign w_rs   = r_ir[INSTR_W-OP_W-RA_W-1 -: RA_W];
  assign w_addr = r_ir[ADDR_W-1:0];

  // LDI immediate: zero-extend or truncate to the data width
  generate
    if (DATA_W > ADDR_W) begin : g_imm_ext
      assign w_imm = {{(DATA_W-ADDR_W){1'b0}}, w_addr};
    end else begin : g_imm_trunc
      assign w_imm = w_addr[DATA_W-1:0];
    end
  endgenerate

  logic w_st_idle, w_st_exec, w_st_mem, w_st_irq;
  assign w_st_idle = (r_state == S_IDLE);
  assign w_st_exec = (r_state == S_EXEC);
  assign w_st_mem  = (r_state == S_MEM);
  assign w_st_irq  = (r_state == S_IRQ);

  logic w_is_alu, w_is_ldi, w_is_ld, w_is_st;
  logic w_is_out, w_is_ei, w_is_di, w_is_ill;
  assign w_is_alu = (w_op >= OP_ADD) && (w_op <= OP_NOT);
  assign w_is_ldi = (w_op == OP_LDI);
  assign w_is_ld  = (w_op == OP_LOAD);
  assign w_is_st  = (w_op == OP_STORE);
  assign w_is_out = (w_op == OP_OUT);
  assign w_is_ei  = (w_op == OP_EI);
  assign w_is_di  = (w_op == OP_DI);
  assign w_is_ill = (w_op > OP_DI);

  logic w_irq_take, w_ready, w_xfer, w_mem_we;
  assign w_irq_take = irq_i && r_ie;
  assign w_ready    = w_st_idle && !w_irq_take;
  assign w_xfer     = ifc.instr_valid_i && w_ready;
  assign w_mem_we   = w_st_exec && w_is_st;

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a      (r_regs[w_rd]),
    .i_b      (r_regs[w_rs]),
    .i_op     (w_op),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags)
  );

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_addr] <= r_regs[w_rs];
    r_rdata <= r_mem[w_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ir     <= '0;
      r_psw    <= '0;
      r_ie     <= 1'b1;
      r_dout   <= '0;
      r_dout_v <= 1'b0;
      r_ill    <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_dout_v <= 1'b0;
      r_ill    <= 1'b0;
      unique case (1'b1)
        w_st_idle: begin
          if (w_xfer) begin
            r_ir    <= ifc.instr_i;
            r_state <= S_EXEC;
          end else if (w_irq_take) begin
            r_state <= S_IRQ;
          end
        end
        w_st_exec: begin
          r_state <= S_IDLE;
          unique case (1'b1)
            w_is_alu: begin
              r_regs[w_rd] <= w_alu_res;
              r_psw        <= w_alu_flags;
            end
            w_is_ldi: r_regs[w_rd] <= w_imm;
            w_is_ld:  r_state <= S_MEM;
            w_is_out: begin
              r_dout   <= r_regs[w_rs];
              r_dout_v <= 1'b1;
            end
            w_is_ei:  r_ie  <= 1'b1;
            w_is_di:  r_ie  <= 1'b0;
            w_is_ill: r_ill <= 1'b1;
            default: ;
          endcase
        end
        w_st_mem: begin
          r_regs[w_rd] <= r_rdata;
          r_state      <= S_IDLE;
        end
        w_st_irq: begin
          r_ie    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ifc.instr_ready_o = w_ready;
  assign irq_ack_o    = w_st_irq;
  assign irq_vec_o    = w_st_irq ? ADDR_W'(IRQ_VEC) : '0;
  assign dout_o       = r_dout;
  assign dout_valid_o = r_dout_v;
  assign psw_o        = r_psw;
  assign ie_o         = r_ie;
  assign illegal_o    = r_ill;

endmodule

// File: tb/tb_param_cpu_core.sv
// Bench for param_cpu_core: directed program with an ISA-level model.
module tb_param_cpu_core;

  localparam int IW   = 18;
  localparam int VEC  = 44;
  localparam int MASK = 255;
  localparam int HALF = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       irq = 1'b0;
  logic       irq_ack;
  logic [7:0] irq_vec;
  logic [7:0] dout;
  logic       dv;
  logic [3:0] psw;
  logic       ie;
  logic       ill;

  param_cpu_core_if #(.INSTR_W(IW)) ifc ();

  param_cpu_core #(
    .IRQ_VEC (VEC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifc          (ifc),
    .irq_i        (irq),
    .irq_ack_o    (irq_ack),
    .irq_vec_o    (irq_vec),
    .dout_o       (dout),
    .dout_valid_o (dv),
    .psw_o        (psw),
    .ie_o         (ie),
    .illegal_o    (ill)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_ack = 0;
  int n_ill = 0;
  bit chk_en = 0;

  int m_regs [8];
  int m_mem [256];
  int m_psw = 0;
  bit m_ie = 1;
  int m_dout = 0;
  bit e_dv = 0;
  bit e_ill = 0;
  bit e_ack = 0;
  int busy = 0;
  bit pend_irq = 0;
  bit acc, ent;
  logic [IW-1:0] pend;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] enc(int op, int rd, int rs, int imm);
    return {op[3:0], rd[2:0], rs[2:0], imm[7:0]};
  endfunction

  // Architectural effect of one instruction on the model state
  task automatic m_exec(input logic [IW-1:0] ins);
    int op, rd, rs, imm, a, b, r;
    bit c, v;
    op = int'(ins[17:14]);
    rd = int'(ins[13:11]);
    rs = int'(ins[10:8]);
    imm = int'(ins[7:0]);
    a = m_regs[rd];
    b = m_regs[rs];
    r = 0; c = 0; v = 0;
    case (op)
      1: m_regs[rd] = m_mem[imm];
      2: m_mem[imm] = m_regs[rs];
      3: begin
        r = a + b;
        c = (r > MASK);
        r = r & MASK;
`ifdef CPU_SAT_ARITH_EN
        if (c) r = MASK;
`endif
        v = ((a >= HALF) == (b >= HALF)) && ((r >= HALF) != (a >= HALF));
      end
      4: begin
        c = (a < b);
        r = (a - b) & MASK;
`ifdef CPU_SAT_ARITH_EN
        if (c) r = 0;
`endif
        v = ((a >= HALF) != (b >= HALF)) && ((r >= HALF) != (a >= HALF));
      end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = (~b) & MASK;
      9: m_regs[rd] = imm & MASK;
      10: begin
        m_dout = m_regs[rs];
        e_dv = 1;
      end
      11: m_ie = 1;
      12: m_ie = 0;
      13, 14, 15: e_ill = 1;
      default: ;
    endcase
    if (op >= 3 && op <= 8) begin
      m_regs[rd] = r;
      m_psw = 8 * int'(v) + 4 * int'(r >= HALF) + 2 * int'(c) + int'(r == 0);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_psw = 0; m_ie = 1; m_dout = 0;
      e_dv = 0; e_ill = 0; e_ack = 0; busy = 0;
    end else begin
      acc = (busy == 0) && ifc.instr_valid_i && !(irq && m_ie);
      ent = (busy == 0) && irq && m_ie;
      e_dv = 0; e_ill = 0; e_ack = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          if (pend_irq) m_ie = 0;
          else m_exec(pend);
        end
      end
      if (acc) begin
        pend = ifc.instr_i;
        pend_irq = 0;
        busy = (ifc.instr_i[17:14] == 4'd1) ? 2 : 1;
      end
      if (ent) begin
        pend_irq = 1;
        busy = 1;
        e_ack = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("dout", dout, m_dout);
      chk("dout_valid", dv, e_dv);
      chk("illegal", ill, e_ill);
      chk("irq_ack", irq_ack, e_ack);
      chk("irq_vec", irq_vec, e_ack ? VEC : 0);
      chk("psw", psw, m_psw);
      chk("ie", ie, m_ie);
      chk("ready", ifc.instr_ready_o, (busy == 0) && !(irq && m_ie));
      if (irq_ack === 1'b1) n_ack++;
      if (ill === 1'b1) n_ill++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [IW-1:0] ins);
    int n;
    n = 0;
    ifc.instr_i = ins;
    ifc.instr_valid_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.instr_ready_o !== 1'b1 && n < 40);
    chk("accept", ifc.instr_ready_o, 1);
    if (ifc.instr_ready_o !== 1'b1) begin
      ifc.instr_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ifc.instr_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lo;
    ifc.instr_i = '0;
    ifc.instr_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1;
    step(3);
    rst_n = 1'b1;
    chk("rst_psw", psw, 0);
    chk("rst_ie", ie, 1);
    chk("rst_dout", dout, 0);

    issue(enc(9, 1, 0, 5));
    issue(enc(9, 2, 0, 3));
    issue(enc(3, 1, 2, 0));
    issue(enc(10, 0, 1, 0));
    step(2);
    chk("add_out", dout, 8);
    chk("add_psw", psw, 0);

    issue(enc(9, 1, 0, 8'h80));
    issue(enc(9, 2, 0, 8'h80));
    issue(enc(3, 1, 2, 0));
    step(2);
`ifdef CPU_SAT_ARITH_EN
    chk("ovf_psw", psw, 4'b0110);
`else
    chk("ovf_psw", psw, 4'b1011);
`endif
    issue(enc(10, 0, 1, 0));
    step(2);
`ifdef CPU_SAT_ARITH_EN
    chk("ovf_out", dout, 8'hFF);
`else
    chk("ovf_out", dout, 8'h00);
`endif

    issue(enc(9, 3, 0, 8'h5A));
    issue(enc(2, 0, 3, 8'h10));
    issue(enc(1, 4, 0, 8'h10));
    lo = 0;
    repeat (4) begin
      if (ifc.instr_ready_o === 1'b0) lo++;
      step(1);
    end
    chk("load_stall", lo, 2);
    issue(enc(10, 0, 4, 0));
    step(2);
    chk("load_out", dout, 8'h5A);

    issue(enc(9, 1, 0, 7));
    issue(enc(4, 1, 1, 0));
    step(2);
    chk("sub_self_psw", psw, 4'b0001);
    issue(enc(9, 1, 0, 2));
    issue(enc(9, 2, 0, 3));
    issue(enc(4, 1, 2, 0));
    step(2);
`ifdef CPU_SAT_ARITH_EN
    chk("borrow_psw", psw, 4'b0011);
`else
    chk("borrow_psw", psw, 4'b0110);
`endif
    issue(enc(10, 0, 1, 0));
    step(2);
`ifdef CPU_SAT_ARITH_EN
    chk("borrow_out", dout, 8'h00);
`else
    chk("borrow_out", dout, 8'hFF);
`endif

    irq = 1'b1;
    issue(enc(9, 5, 0, 8'h33));
    chk("irq_ie_off", ie, 0);
    issue(enc(10, 0, 5, 0));
    step(2);
    chk("irq_held_out", dout, 8'h33);
    issue(enc(11, 0, 0, 0));
    step(4);
    chk("irq_reenter_ie", ie, 0);
    irq = 1'b0;

    issue(enc(14, 1, 2, 0));
    step(2);
`ifdef CPU_SAT_ARITH_EN
    chk("ill_psw", psw, 4'b0011);
`else
    chk("ill_psw", psw, 4'b0110);
`endif
    issue(enc(10, 0, 1, 0));
    step(2);
`ifdef CPU_SAT_ARITH_EN
    chk("ill_reg", dout, 8'h00);
`else
    chk("ill_reg", dout, 8'hFF);
`endif

    issue(enc(1, 4, 0, 8'h10));
    step(1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    chk("rst2_psw", psw, 0);
    chk("rst2_ie", ie, 1);
    issue(enc(1, 6, 0, 8'h10));
    issue(enc(10, 0, 6, 0));
    step(2);
    chk("mem_kept", dout, 8'h5A);
    issue(enc(10, 0, 4, 0));
    step(2);
    chk("reg_cleared", dout, 0);

    chk("ack_count", n_ack, 2);
    chk("ill_count", n_ill, 1);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/param_cpu_core.md
Name: param_cpu_core

Overview:
- Parametrised multi-cycle processor core: register file, ALU, flag register (PSW), internal data memory and one-level interrupt entry.
- Instructions arrive over a valid/ready handshake from an external instruction source.
- Results are emitted on a registered output port.
- Successor to the fixed 8-bit core: configurable width, register count and memory depth; adds an FSM, flags, handshake and interrupt sequencing.

Parameters:
- DATA_W, 8, datapath/register/memory word width (>=4)
- NREGS, 8, number of general registers (power of 2, >=2); RA_W = clog2(NREGS)
- MEM_DEPTH, 256, data memory words (power of 2); ADDR_W = clog2(MEM_DEPTH)
- IRQ_VEC, 0, value presented on irq_vec_o during interrupt entry (ADDR_W bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- instr_i  in  INSTR_W=4+2*RA_W+ADDR_W  instruction fields:
  - op = [MSB -: 4]
  - rd = next RA_W bits
  - rs = next RA_W bits
  - imm/addr = low ADDR_W bits
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  core accepts instruction this cycle
- irq_i  in  1  level interrupt request
- irq_ack_o  out  1  one-cycle interrupt-entry pulse
- irq_vec_o  out  ADDR_W  IRQ_VEC while irq_ack_o=1, else 0
- dout_o  out  DATA_W  registered output data
- dout_valid_o  out  1  one-cycle pulse with dout_o
- psw_o  out  4  {V,N,C,Z}
- ie_o  out  1  interrupt enable
- illegal_o  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (async assert, sync deassert by clk):
  - state=IDLE; all registers=0; psw_o=0; ie_o=1
  - dout_o=0; dout_valid_o, irq_ack_o, illegal_o=0
  - memory contents unaffected, undefined after power-up
- Opcodes:
  - 0 NOP
  - 1 LOAD rd<=mem[addr]
  - 2 STORE mem[addr]<=R[rs]
  - 3 ADD rd<=rd+rs
  - 4 SUB rd<=rd-rs
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 NOT rd<=~rs
  - 9 LDI rd<=zero-extended imm (truncated if ADDR_W>DATA_W)
  - 10 OUT dout_o<=R[rs]
  - 11 EI
  - 12 DI
  - 13-15 illegal
- instr_ready_o = (state==IDLE) && !(irq_i && ie_o); combinational. A transfer occurs when valid&&ready at a clk edge; instruction latched into IR.
- FSM:
  - IDLE: on transfer -> EXEC. Else if irq_i&&ie_o -> IRQ.
  - EXEC: ALU/LDI/NOT write rd and flags. STORE writes memory. OUT drives dout_o and pulses dout_valid_o. EI/DI update ie_o. Illegal pulses illegal_o with no state change. All of these -> IDLE. LOAD issues synchronous memory read -> MEM.
  - MEM: rd<=read data -> IDLE.
  - IRQ: irq_ack_o=1, ie_o<=0 -> IDLE.
- Latency from accept edge: ALU/OUT/STORE effects visible 1 cycle later; LOAD 2 cycles; throughput 1 instr/2 cycles (LOAD 1/3).
- Flags (ALU ops 3-8 only; other ops leave PSW):
  - Z: result==0
  - N: result MSB
  - ADD: C=carry-out; V=signed overflow
  - SUB: C=borrow (rd<rs unsigned); V=signed overflow
  - AND/OR/XOR/NOT: C=V=0
- rd==rs is legal (ADD doubles, SUB gives 0 with Z=1).
- irq_i and instr_valid_i both high in IDLE with ie_o=1: interrupt wins, instruction not accepted and must be held by the source.
- irq_i while ie_o=0 is ignored until EI. irq_i still high after entry does not re-enter (ie_o=0).
- Reset asserted mid-LOAD/STORE: operation aborted; a STORE already at its EXEC edge has completed.

Optional Feature:
- CPU_SAT_ARITH_EN defined: ADD clamps to 2^DATA_W-1 on carry; SUB clamps to 0 on borrow. C/V/N/Z computed on the clamped result except C, which still reports carry/borrow.
- Undefined: wrap-around arithmetic.

Decomposition:
- Package cpu_core_pkg:
  - opcode localparams/enum
  - FSM state enum
  - PSW bit indices (Z=0,C=1,N=2,V=3)
  - op-field width 4
- One sub-module: cpu_alu. Combinational; parametrised by DATA_W. Inputs a, b, op; outputs result and flags. Contains the saturation option.

Test Plan:
- Reset, LDI R1,5; LDI R2,3; ADD R1,R2; OUT R1 -> dout_o=8, dout_valid_o 1 cycle, psw_o=0000.
- LDI R1,0x80; LDI R2,0x80; ADD R1,R2 -> R1=0x00, Z=1, C=1, V=1, N=0 (with CPU_SAT_ARITH_EN: R1=0xFF, Z=0, N=1, C=1).
- LDI R3,0x5A; STORE [0x10],R3; LOAD R4,[0x10]; OUT R4 -> dout_o=0x5A; LOAD takes 3 cycles, instr_ready_o low 2 cycles.
- SUB R1,R1 after LDI R1,7 -> 0, Z=1, C=0. LDI R1,2; LDI R2,3; SUB R1,R2 -> 0xFF, C=1, N=1.
- irq_i=1 concurrent with instr_valid_i in IDLE -> instruction stalled, irq_ack_o 1 cycle, irq_vec_o=IRQ_VEC, ie_o=0, then instruction accepted; second irq ignored until EI.
- Opcode 14 -> illegal_o pulse, registers/PSW unchanged. rst_n low during LOAD -> registers 0, state IDLE, memory preserved.
